pwm_capture: RTL and testbench

- Measures an external PWM waveform, such as an RC receiver channel or an ESC feedback line.
- Reports period and high-time as 28-bit clock-cycle counts.
- Uses the same 28-bit format that the Nios II system drives on its cycle/duty PIO exports.
- It is the read side of the PWM path: its outputs feed input PIOs, so software can close the loop on measured timing.

---
 rtl/pwm_capture.sv | 183 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with a 2-flop synchronizer and a timeout.
// Optional glitch filter after the synchronizer: define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W       = 28,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] cycle_out,
  output logic [CNT_W-1:0] duty_out,
  output logic             valid,
  output logic             timeout,
  output logic             level
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);
  localparam int               WCW     = $clog2(FILT_LEN + 4);

  logic sync1_q, sync2_q;
  logic s;
  logic prev_q;
  logic rise_det, fall_det;
  logic edges_ok;
  logic [WCW-1:0] warm_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      prev_q  <= s;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCW  = $clog2(FILT_LEN + 1);
  localparam int WARM = FILT_LEN + 3;

  logic [FCW-1:0] fcnt_q;
  logic           filt_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else if (sync2_q != filt_q) begin
      if (fcnt_q == FCW'(FILT_LEN - 1)) begin
        filt_q <= sync2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FCW'(1);
      end
    end else begin
      fcnt_q <= '0;
    end
  end

  assign s = filt_q;
`else
  localparam int WARM = 3;

  assign s = sync2_q;
`endif

  // The synchronizer restarts from 0 on reset; mask edges until s and prev_q
  // both reflect the real input again, so a level held high across reset
  // does not look like a fresh rising edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      warm_q <= '0;
    end else if (warm_q != WCW'(WARM)) begin
      warm_q <= warm_q + WCW'(1);
    end
  end

  assign edges_ok = (warm_q == WCW'(WARM));
  assign rise_det = edges_ok &  s & ~prev_q;
  assign fall_det = edges_ok & ~s &  prev_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      cycle_q   <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      cycle_q   <= cycle_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pcnt_d    = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_ONE;
    hcnt_d    = hcnt_q;
    cycle_d   = cycle_q;
    duty_d    = duty_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!enable) begin
      state_d = IDLE;
      pcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise_det) begin
            state_d = HIGH;
            pcnt_d  = CNT_ONE;
          end
        end
        HIGH: begin
          if (pcnt_q >= TO_VAL) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            cycle_d   = '0;
            duty_d    = '0;
          end else if (fall_det) begin
            hcnt_d  = pcnt_q;
            state_d = LOW;
          end
        end
        LOW: begin
          // A rise in the same cycle as the timeout compare still publishes.
          if (rise_det) begin
            cycle_d   = pcnt_q;
            duty_d    = hcnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            pcnt_d    = CNT_ONE;
            state_d   = HIGH;
          end else if (pcnt_q >= TO_VAL) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            cycle_d   = '0;
            duty_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign cycle_out = cycle_q;
  assign duty_out  = duty_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign level     = s;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: arming, duty change, timeout, reset, enable, glitch.
module tb_pwm_capture;

  localparam int CNT_W = 28;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FEXTRA = 4;
`else
  localparam int FEXTRA = 0;
`endif

  logic             clk_clk = 1'b0;
  logic             reset_reset;
  logic             enable;
  logic             pwm_in;
  logic [CNT_W-1:0] cycle_out;
  logic [CNT_W-1:0] duty_out;
  logic             valid;
  logic             timeout;
  logic             level;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  logic [CNT_W-1:0] last_cyc  = '0;
  logic [CNT_W-1:0] last_duty = '0;
  int vb;

  pwm_capture #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(1000),
    .FILT_LEN   (4)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .cycle_out  (cycle_out),
    .duty_out   (duty_out),
    .valid      (valid),
    .timeout    (timeout),
    .level      (level)
  );

  always #5 clk_clk = ~clk_clk;

  // Records every valid pulse and checks the duty < period relation.
  always @(negedge clk_clk) begin
    if (valid === 1'b1) begin
      vcount    = vcount + 1;
      last_cyc  = cycle_out;
      last_duty = duty_out;
      total     = total + 1;
      assert (duty_out < cycle_out) else begin
        bad = bad + 1;
        $display("FAIL invariant: duty=%0d cycle=%0d", duty_out, cycle_out);
        $error("invariant");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic period(input int hi, input int per);
    pwm_in = 1'b1;
    cyc(hi);
    pwm_in = 1'b0;
    cyc(per - hi);
  endtask

  initial begin
    reset_reset = 1'b1;
    enable      = 1'b0;
    pwm_in      = 1'b0;
    cyc(3);
    reset_reset = 1'b0;
    chk("rst_cycle", 32'(cycle_out), 0);
    chk("rst_duty", 32'(duty_out), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_timeout", 32'(timeout), 1);
    chk("rst_level", 32'(level), 0);
    cyc(10);
    enable = 1'b1;

    // Arming: the first rise produces nothing
    period(25, 100);
    chk("arm_vcount", vcount, 0);
    chk("arm_timeout", 32'(timeout), 1);
    period(25, 100);
    period(25, 100);
    chk("meas_vcount", vcount, 2);
    chk("meas_cycle", 32'(last_cyc), 100);
    chk("meas_duty", 32'(last_duty), 25);
    chk("meas_timeout", 32'(timeout), 0);

    // Duty change 25 -> 70
    period(70, 100);
    chk("dchg1_vcount", vcount, 3);
    chk("dchg1_duty", 32'(last_duty), 25);
    period(70, 100);
    chk("dchg2_vcount", vcount, 4);
    chk("dchg2_cycle", 32'(last_cyc), 100);
    chk("dchg2_duty", 32'(last_duty), 70);

    // Timeout: hold high after a valid period
    period(25, 100);
    pwm_in = 1'b1;
    cyc(1002 + FEXTRA);
    chk("to_pre_timeout", 32'(timeout), 0);
    chk("to_pre_cycle", 32'(cycle_out), 100);
    chk("to_pre_duty", 32'(duty_out), 25);
    cyc(1);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_cycle", 32'(cycle_out), 0);
    chk("to_duty", 32'(duty_out), 0);
    chk("to_vcount", vcount, 6);
    pwm_in = 1'b0;
    cyc(10);
    period(25, 100);
    chk("rearm_vcount", vcount, 6);
    chk("rearm_timeout", 32'(timeout), 1);
    period(25, 100);
    chk("rearm2_vcount", vcount, 7);
    chk("rearm2_cycle", 32'(last_cyc), 100);
    chk("rearm2_duty", 32'(last_duty), 25);
    chk("rearm2_timeout", 32'(timeout), 0);

    // Reset for one clock during HIGH
    pwm_in = 1'b1;
    cyc(10);
    reset_reset = 1'b1;
    cyc(1);
    reset_reset = 1'b0;
    chk("mrst_cycle", 32'(cycle_out), 0);
    chk("mrst_duty", 32'(duty_out), 0);
    chk("mrst_valid", 32'(valid), 0);
    chk("mrst_timeout", 32'(timeout), 1);
    chk("mrst_level", 32'(level), 0);
    vb = vcount;
    cyc(15);
    pwm_in = 1'b0;
    cyc(75);
    period(25, 100);
    chk("mrst_a_vcount", vcount, vb);
    period(25, 100);
    chk("mrst_b_vcount", vcount, vb + 1);
    chk("mrst_b_cycle", 32'(last_cyc), 100);
    chk("mrst_b_duty", 32'(last_duty), 25);

    // enable low for 500 clocks
    vb = vcount;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) period(25, 100);
    chk("en_vcount", vcount, vb);
    chk("en_cycle", 32'(cycle_out), 100);
    chk("en_duty", 32'(duty_out), 25);
    chk("en_timeout", 32'(timeout), 0);
    chk("en_valid", 32'(valid), 0);
    enable = 1'b1;
    period(25, 100);
    chk("en_a_vcount", vcount, vb);
    period(25, 100);
    chk("en_b_vcount", vcount, vb + 1);
    chk("en_b_cycle", 32'(last_cyc), 100);

    // 2-clock low glitch inside the high phase
    vb = vcount;
    pwm_in = 1'b1;
    cyc(10);
    pwm_in = 1'b0;
    cyc(2);
    pwm_in = 1'b1;
    cyc(13);
    pwm_in = 1'b0;
    cyc(75);
`ifdef PWM_CAPTURE_FILTER_EN
    chk("gl1_vcount", vcount, vb + 1);
    chk("gl1_duty", 32'(last_duty), 25);
    period(25, 100);
    chk("gl2_vcount", vcount, vb + 2);
    chk("gl2_cycle", 32'(last_cyc), 100);
    chk("gl2_duty", 32'(last_duty), 25);
`else
    chk("gl1_vcount", vcount, vb + 2);
    chk("gl1_cycle", 32'(last_cyc), 12);
    chk("gl1_duty", 32'(last_duty), 10);
    period(25, 100);
    chk("gl2_vcount", vcount, vb + 3);
    chk("gl2_cycle", 32'(last_cyc), 88);
    chk("gl2_duty", 32'(last_duty), 13);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
